control_sequencer: RTL and testbench

//  Moore-style control unit for the single-bus Mini SRC datapath.

---
 rtl/control_sequencer.sv | 257 +++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Mini SRC single-bus control unit: fetch T0-T2, per-opcode execute T3-T7.
// Memory waits are bounded; a timeout latches mem_err and halts.
module control_sequencer #(
  parameter int          MEM_WAIT_MAX = 15,
  parameter logic [4:0]  OP_ADD       = 5'b00011
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        mem_ready,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        rin,
  output logic        rout,
  output logic        ba_out,
  output logic        pc_out,
  output logic        pc_in,
  output logic        inc_pc,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        c_out,
  output logic        zlow_out,
  output logic        zhigh_out,
  output logic        hi_in,
  output logic        lo_in,
  output logic        con_in,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic        mem_err
);

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MEM_WAIT_MAX - 1);

  typedef enum logic [3:0] {
    T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_t;

  typedef struct packed {
    logic gra, grb, grc, rin, rout, ba_out;
    logic pc_out, pc_in, inc_pc;
    logic mar_in, mdr_in, mdr_out;
    logic mem_read, mem_write;
    logic ir_in, y_in, z_in, c_out;
    logic zlow_out, zhigh_out, hi_in, lo_in, con_in;
  } ctl_t;

  state_t          state, state_n;
  logic [CW-1:0]   wait_cnt;
  logic            cnt_inc, err_set, mem_wait;
  ctl_t            ctl, ctl_o;
  logic [4:0]      alu, op;
  logic            is_r, is_imm, is_ldi, is_ld, is_st;
  logic            is_md, is_br, is_jr, is_halt, is_base;
  logic            unused_ir;

  assign op        = ir[31:27];
  assign unused_ir = ^ir[26:0];
  assign is_r      = (op >= 5'd3) && (op <= 5'd11);
  assign is_imm    = (op >= 5'd12) && (op <= 5'd14);
  assign is_ldi    = (op == 5'd1);
  assign is_ld     = (op == 5'd0);
  assign is_st     = (op == 5'd2);
  assign is_md     = (op == 5'd15) || (op == 5'd16);
  assign is_br     = (op == 5'd19);
  assign is_jr     = (op == 5'd20);
  assign is_halt   = (op == 5'd27);
  assign is_base   = is_ldi || is_ld || is_st;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= T0;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= cnt_inc ? wait_cnt + CW'(1) : '0;
      mem_err  <= mem_err | err_set;
    end
  end

  always_comb begin
    ctl      = '0;
    alu      = '0;
    state_n  = state;
    mem_wait = 1'b0;
    cnt_inc  = 1'b0;
    err_set  = 1'b0;
    unique case (state)
      T0: begin
        ctl.pc_out = 1'b1; ctl.mar_in = 1'b1;
        ctl.inc_pc = 1'b1; ctl.z_in   = 1'b1;
        state_n = T1;
      end
      T1: begin
        ctl.zlow_out = 1'b1; ctl.pc_in  = 1'b1;
        ctl.mem_read = 1'b1; ctl.mdr_in = 1'b1;
        mem_wait = 1'b1;
        state_n  = T2;
      end
      T2: begin
        ctl.mdr_out = 1'b1; ctl.ir_in = 1'b1;
        state_n = T3;
      end
      T3: begin
        state_n = T4;
        unique case (1'b1)
          is_r, is_imm: begin
            ctl.grb = 1'b1; ctl.rout = 1'b1; ctl.y_in = 1'b1;
          end
          is_base: begin
            ctl.grb = 1'b1; ctl.ba_out = 1'b1; ctl.y_in = 1'b1;
          end
          is_md: begin
            ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.y_in = 1'b1;
          end
          is_br: begin
            ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.con_in = 1'b1;
          end
          is_jr: begin
            ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.pc_in = 1'b1;
            state_n = T0;
          end
          is_halt: state_n = HALT;
          default: state_n = T0;
        endcase
      end
      T4: begin
        state_n = T5;
        unique case (1'b1)
          is_r: begin
            ctl.grc = 1'b1; ctl.rout = 1'b1; ctl.z_in = 1'b1;
            alu = op;
          end
          is_imm: begin
            ctl.c_out = 1'b1; ctl.z_in = 1'b1;
            alu = op;
          end
          is_base: begin
            ctl.c_out = 1'b1; ctl.z_in = 1'b1;
            alu = OP_ADD;
          end
          is_md: begin
            ctl.grb = 1'b1; ctl.rout = 1'b1; ctl.z_in = 1'b1;
            alu = op;
          end
          is_br: begin
            ctl.pc_out = 1'b1; ctl.y_in = 1'b1;
          end
          default: state_n = T0;
        endcase
      end
      T5: begin
        state_n = T6;
        unique case (1'b1)
          is_r, is_imm, is_ldi: begin
            ctl.zlow_out = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1;
            state_n = T0;
          end
          is_ld, is_st: begin
            ctl.zlow_out = 1'b1; ctl.mar_in = 1'b1;
          end
          is_md: begin
            ctl.zlow_out = 1'b1; ctl.lo_in = 1'b1;
          end
          is_br: begin
            ctl.c_out = 1'b1; ctl.z_in = 1'b1;
            alu = OP_ADD;
          end
          default: state_n = T0;
        endcase
      end
      T6: begin
        state_n = T0;
        unique case (1'b1)
          is_ld: begin
            ctl.mem_read = 1'b1; ctl.mdr_in = 1'b1;
            mem_wait = 1'b1;
            state_n  = T7;
          end
          is_st: begin
            ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.mdr_in = 1'b1;
            state_n = T7;
          end
          is_md: begin
            ctl.zhigh_out = 1'b1; ctl.hi_in = 1'b1;
          end
          is_br: begin
            ctl.zlow_out = con_ff; ctl.pc_in = con_ff;
          end
          default: ;
        endcase
      end
      T7: begin
        state_n = T0;
        unique case (1'b1)
          is_ld: begin
            ctl.mdr_out = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1;
          end
          is_st: begin
            ctl.mem_write = 1'b1;
            mem_wait = 1'b1;
          end
          default: ;
        endcase
      end
      HALT:    state_n = HALT;
      default: state_n = T0;
    endcase
    // Stalled memory step: hold the strobes, count, give up at the limit.
    if (mem_wait && !mem_ready) begin
      if (wait_cnt == LIMIT) begin
        state_n = HALT;
        err_set = 1'b1;
      end else begin
        state_n = state;
        cnt_inc = 1'b1;
      end
    end
  end

  assign ctl_o     = reset_n ? ctl : '0;
  assign alu_op    = reset_n ? alu : '0;
  assign run       = (state != HALT);
  assign gra       = ctl_o.gra;
  assign grb       = ctl_o.grb;
  assign grc       = ctl_o.grc;
  assign rin       = ctl_o.rin;
  assign rout      = ctl_o.rout;
  assign ba_out    = ctl_o.ba_out;
  assign pc_out    = ctl_o.pc_out;
  assign pc_in     = ctl_o.pc_in;
  assign inc_pc    = ctl_o.inc_pc;
  assign mar_in    = ctl_o.mar_in;
  assign mdr_in    = ctl_o.mdr_in;
  assign mdr_out   = ctl_o.mdr_out;
  assign mem_read  = ctl_o.mem_read;
  assign mem_write = ctl_o.mem_write;
  assign ir_in     = ctl_o.ir_in;
  assign y_in      = ctl_o.y_in;
  assign z_in      = ctl_o.z_in;
  assign c_out     = ctl_o.c_out;
  assign zlow_out  = ctl_o.zlow_out;
  assign zhigh_out = ctl_o.zhigh_out;
  assign hi_in     = ctl_o.hi_in;
  assign lo_in     = ctl_o.lo_in;
  assign con_in    = ctl_o.con_in;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: vector table of fetch/execute
// steps plus hand sequences for waits, branches, timeout, reset and halt.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] ir;
  logic        con_ff, mem_ready;
  logic gra, grb, grc, rin, rout, ba_out, pc_out, pc_in, inc_pc;
  logic mar_in, mdr_in, mdr_out, mem_read, mem_write, ir_in, y_in;
  logic z_in, c_out, zlow_out, zhigh_out, hi_in, lo_in, con_in;
  logic [4:0]  alu_op;
  logic        run, mem_err;

  control_sequencer dut (
    .clock(clock), .reset_n(reset_n), .ir(ir), .con_ff(con_ff),
    .mem_ready(mem_ready),
    .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout),
    .ba_out(ba_out), .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc),
    .mar_in(mar_in), .mdr_in(mdr_in), .mdr_out(mdr_out),
    .mem_read(mem_read), .mem_write(mem_write), .ir_in(ir_in),
    .y_in(y_in), .z_in(z_in), .c_out(c_out), .zlow_out(zlow_out),
    .zhigh_out(zhigh_out), .hi_in(hi_in), .lo_in(lo_in),
    .con_in(con_in), .alu_op(alu_op), .run(run), .mem_err(mem_err)
  );

  always #5 clock = ~clock;

  localparam logic [22:0] GRA  = 23'd1 << 22;
  localparam logic [22:0] GRB  = 23'd1 << 21;
  localparam logic [22:0] GRC  = 23'd1 << 20;
  localparam logic [22:0] RIN  = 23'd1 << 19;
  localparam logic [22:0] ROUT = 23'd1 << 18;
  localparam logic [22:0] BAO  = 23'd1 << 17;
  localparam logic [22:0] PCO  = 23'd1 << 16;
  localparam logic [22:0] PCI  = 23'd1 << 15;
  localparam logic [22:0] INC  = 23'd1 << 14;
  localparam logic [22:0] MARI = 23'd1 << 13;
  localparam logic [22:0] MDRI = 23'd1 << 12;
  localparam logic [22:0] MDRO = 23'd1 << 11;
  localparam logic [22:0] MRD  = 23'd1 << 10;
  localparam logic [22:0] MWR  = 23'd1 << 9;
  localparam logic [22:0] IRI  = 23'd1 << 8;
  localparam logic [22:0] YI   = 23'd1 << 7;
  localparam logic [22:0] ZI   = 23'd1 << 6;
  localparam logic [22:0] COUT = 23'd1 << 5;
  localparam logic [22:0] ZLO  = 23'd1 << 4;
  localparam logic [22:0] ZHO  = 23'd1 << 3;
  localparam logic [22:0] HII  = 23'd1 << 2;
  localparam logic [22:0] LOI  = 23'd1 << 1;
  localparam logic [22:0] CONI = 23'd1;
  localparam logic [22:0] F0   = PCO | MARI | INC | ZI;
  localparam logic [22:0] F1   = ZLO | PCI | MRD | MDRI;
  localparam logic [22:0] F2   = MDRO | IRI;
  localparam logic [22:0] NONE = 23'd0;

  localparam logic [31:0] I_ADD  = 32'h18918000;
  localparam logic [31:0] I_ADDI = 32'h60000000;
  localparam logic [31:0] I_LDI  = 32'h08000000;
  localparam logic [31:0] I_LD   = 32'h00000000;
  localparam logic [31:0] I_ST   = 32'h10000000;
  localparam logic [31:0] I_MUL  = 32'h80000000;
  localparam logic [31:0] I_BR   = 32'h98000000;
  localparam logic [31:0] I_JR   = 32'hA0000000;
  localparam logic [31:0] I_NOP  = 32'hD0000000;
  localparam logic [31:0] I_HALT = 32'hD8000000;

  typedef struct {
    logic [31:0] ir;
    logic        rdy;
    logic [22:0] ctl;
    logic [4:0]  alu;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [22:0] ctl,
                     input logic [4:0] alu, input logic r,
                     input logic e);
    logic [30:0] got, exp;
    got = {gra, grb, grc, rin, rout, ba_out, pc_out, pc_in, inc_pc,
           mar_in, mdr_in, mdr_out, mem_read, mem_write, ir_in, y_in,
           z_in, c_out, zlow_out, zhigh_out, hi_in, lo_in, con_in,
           alu_op, run, mem_err};
    exp = {ctl, alu, r, e};
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got ctl=%h alu=%b run=%b err=%b, want ctl=%h alu=%b run=%b err=%b",
               tag, got[30:8], got[7:3], got[2], got[1],
               ctl, alu, r, e);
    end
  endtask

  // Called at a negedge: drive, check the Moore outputs, advance one cycle.
  task automatic apply(input string tag, input logic [31:0] i,
                       input logic c, input logic rdy,
                       input logic [22:0] ctl, input logic [4:0] alu,
                       input logic r, input logic e);
    ir = i; con_ff = c; mem_ready = rdy;
    #1;
    chk(tag, ctl, alu, r, e);
    @(negedge clock);
  endtask

  task automatic add(input logic [31:0] i, input logic [22:0] ctl,
                     input logic [4:0] alu);
    vec_t v;
    v.ir = i; v.rdy = 1'b1; v.ctl = ctl; v.alu = alu;
    tbl.push_back(v);
  endtask

  task automatic fetch(input logic [31:0] i);
    add(i, F0, 5'd0);
    add(i, F1, 5'd0);
    add(i, F2, 5'd0);
  endtask

  task automatic run_fetch(input string tag, input logic [31:0] i,
                           input logic c);
    apply({tag, "_t0"}, i, c, 1'b1, F0, 5'd0, 1'b1, 1'b0);
    apply({tag, "_t1"}, i, c, 1'b1, F1, 5'd0, 1'b1, 1'b0);
    apply({tag, "_t2"}, i, c, 1'b1, F2, 5'd0, 1'b1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fetch(I_ADD);
    add(I_ADD, GRB | ROUT | YI, 5'd0);
    add(I_ADD, GRC | ROUT | ZI, 5'b00011);
    add(I_ADD, ZLO | GRA | RIN, 5'd0);
    fetch(I_ADDI);
    add(I_ADDI, GRB | ROUT | YI, 5'd0);
    add(I_ADDI, COUT | ZI, 5'b01100);
    add(I_ADDI, ZLO | GRA | RIN, 5'd0);
    fetch(I_LDI);
    add(I_LDI, GRB | BAO | YI, 5'd0);
    add(I_LDI, COUT | ZI, 5'b00011);
    add(I_LDI, ZLO | GRA | RIN, 5'd0);
    fetch(I_ST);
    add(I_ST, GRB | BAO | YI, 5'd0);
    add(I_ST, COUT | ZI, 5'b00011);
    add(I_ST, ZLO | MARI, 5'd0);
    add(I_ST, GRA | ROUT | MDRI, 5'd0);
    add(I_ST, MWR, 5'd0);
    fetch(I_MUL);
    add(I_MUL, GRA | ROUT | YI, 5'd0);
    add(I_MUL, GRB | ROUT | ZI, 5'b10000);
    add(I_MUL, ZLO | LOI, 5'd0);
    add(I_MUL, ZHO | HII, 5'd0);
    fetch(I_JR);
    add(I_JR, GRA | ROUT | PCI, 5'd0);
    fetch(I_NOP);
    add(I_NOP, NONE, 5'd0);

    reset_n = 1'b0; ir = I_ADD; con_ff = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    chk("reset_state", NONE, 5'd0, 1'b1, 1'b0);
    reset_n = 1'b1;

    foreach (tbl[k])
      apply($sformatf("vec%0d", k), tbl[k].ir, 1'b0, tbl[k].rdy,
            tbl[k].ctl, tbl[k].alu, 1'b1, 1'b0);

    run_fetch("ld", I_LD, 1'b0);
    apply("ld_t3", I_LD, 0, 1, GRB | BAO | YI, 5'd0, 1, 0);
    apply("ld_t4", I_LD, 0, 1, COUT | ZI, 5'b00011, 1, 0);
    apply("ld_t5", I_LD, 0, 1, ZLO | MARI, 5'd0, 1, 0);
    for (int w = 0; w < 3; w++)
      apply("ld_t6_wait", I_LD, 0, 0, MRD | MDRI, 5'd0, 1, 0);
    apply("ld_t6_go", I_LD, 0, 1, MRD | MDRI, 5'd0, 1, 0);
    apply("ld_t7", I_LD, 0, 1, MDRO | GRA | RIN, 5'd0, 1, 0);

    for (int c = 0; c < 2; c++) begin
      run_fetch("br", I_BR, c[0]);
      apply("br_t3", I_BR, c[0], 1, GRA | ROUT | CONI, 5'd0, 1, 0);
      apply("br_t4", I_BR, c[0], 1, PCO | YI, 5'd0, 1, 0);
      apply("br_t5", I_BR, c[0], 1, COUT | ZI, 5'b00011, 1, 0);
      apply(c == 0 ? "br_t6_nt" : "br_t6_tk", I_BR, c[0], 1,
            c == 0 ? NONE : (ZLO | PCI), 5'd0, 1, 0);
    end

    run_fetch("rst", I_ADD, 1'b0);
    apply("rst_t3", I_ADD, 0, 1, GRB | ROUT | YI, 5'd0, 1, 0);
    ir = I_ADD; mem_ready = 1'b1;
    #1;
    chk("pre_rst_t4", GRC | ROUT | ZI, 5'b00011, 1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_t4", NONE, 5'd0, 1'b1, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;

    apply("to_t0", I_ADD, 0, 1, F0, 5'd0, 1, 0);
    for (int w = 0; w < 15; w++)
      apply($sformatf("to_t1_w%0d", w), I_ADD, 0, 0, F1, 5'd0, 1, 0);
    for (int w = 0; w < 3; w++)
      apply("to_halted", I_ADD, 0, 1, NONE, 5'd0, 0, 1);

    reset_n = 1'b0;
    #1;
    chk("to_reset", NONE, 5'd0, 1'b1, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;

    run_fetch("halt", I_HALT, 1'b0);
    apply("halt_t3", I_HALT, 0, 1, NONE, 5'd0, 1, 0);
    for (int w = 0; w < 3; w++)
      apply("halt_hold", I_HALT, 0, 1, NONE, 5'd0, 0, 0);
    apply("halt_other_ir", I_ADD, 1, 1, NONE, 5'd0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
